enc_round_ctrl: RTL
===================

# enc_round_ctrl

Multi-round sequencer for the 8-bit nibble-Feistel encryption datapath. It accepts one (number, key) pair per transaction over a valid/ready handshake and iterates the single-round function once per clock for ROUNDS rounds, with a rotating key schedule and a nibble swap between rounds. It holds the result until the consumer takes it. It sits between the host-side number/key source and the downstream consumer, replacing the single-pass register-and-encrypt wrapper.

## Interface
- ROUNDS, 4, number of rounds per transaction; legal range 1..15.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  number/key presented.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_number  in  8  plaintext (or ciphertext when decrypting).
- in_key  in  8  base key.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_number  out  8  result; stable while out_valid is high.
- busy  out  1  high in ROUND or DONE.
- round_cnt  out  4  index of the round being executed; 0 outside ROUND.
- in_decrypt  in  1  present only with ENC_DECRYPT_EN; sampled at acceptance.

## Operation
- Round function f(n, k) is fixed:
  - e = {n[3],n[0],n[1],n[2],n[1],n[3],n[2],n[0]}
  - x = e ^ k
  - s = (x[3:0] + x[7:4] + k[0]) mod 16
  - r = {n[7:4] ^ s, n[3:0]}
- Round i uses round key rotl(in_key, i), a rotate left by i bits. The key register is rotated left by 1 after each round.
- After every round except the last, the datapath register loads {r[3:0], r[7:4]} (nibble swap). After the last round it loads r unswapped.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_number into the data register and in_key into the key register, clear round_cnt, and go to ROUND.
  - ROUND: one round per cycle; round_cnt increments. When round_cnt==ROUNDS-1, apply the final round and go to DONE.
  - DONE: out_valid=1 with out_number = data register. On out_ready, go to IDLE.
- in_valid outside IDLE is ignored; nothing is queued or dropped silently, because in_ready is low.
- Reset values: state IDLE, data and key registers 0, round_cnt 0, in_ready 1 after the first post-reset cycle, out_valid 0, out_number 0, busy 0.
- Reset asserted mid-ROUND or in DONE aborts the transaction; no out_valid is produced for it.
- 4-bit adder carry-out is discarded. All arithmetic is mod 16.

## Timing
- Acceptance edge is T, with in_valid && in_ready.
- Rounds execute on edges T+1 .. T+ROUNDS.
- out_valid rises after edge T+ROUNDS, so latency is ROUNDS cycles.
- out_valid and out_number hold until the edge where out_ready=1. The state is IDLE after that edge, so the next acceptance is possible one edge later.
- Minimum transaction period is ROUNDS+2 cycles with out_ready held high.
- out_ready high while out_valid is low has no effect.

## Configuration
- ENC_DECRYPT_EN defined:
  - Adds the in_decrypt port and a mode bit latched at acceptance.
  - When the mode bit is set, the key register loads rotl(in_key, ROUNDS-1) at acceptance and rotates right by 1 per round. Round structure and swaps are identical to encryption.
  - Decrypting with the same in_key recovers the plaintext.
- ENC_DECRYPT_EN undefined: no in_decrypt port; encryption only.

## Structure
- Package enc_pkg holds:
  - state enum (IDLE, ROUND, DONE)
  - width constants DATA_W=8, NIB_W=4, CNT_W=4
  - functions exp_box(nibble) and rotl8/rotr8
- Sub-module enc_round: purely combinational f(n, k) -> r, instantiated once.
- enc_round_ctrl owns the FSM, the data, key and count registers, and the swap mux.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, out_number=0x00, busy=0, round_cnt=0.
- ROUNDS=1, number 0x46, key 0x93, out_ready=1 -> out_valid one cycle after acceptance, out_number=0x06.
- ROUNDS=2, number 0x46, key 0x93 -> out_number=0xC0 two cycles after acceptance. Hold out_ready=0 for 5 cycles: out_number stays 0xC0 and in_ready stays 0. A new in_valid during this window is ignored.
- ENC_DECRYPT_EN, ROUNDS=2, in_decrypt=1, number 0xC0, key 0x93 -> 0x46. Default ROUNDS=4: random encrypt-then-decrypt round trips return the original number.
- Assert reset on the second ROUND cycle -> no out_valid. Next cycle is IDLE with all outputs at reset values. A fresh transaction then completes correctly.
- Back-to-back transactions with out_ready tied high -> acceptances exactly ROUNDS+2 cycles apart, and round_cnt runs 0..ROUNDS-1 in each.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types, widths and bit helpers for the nibble-Feistel round controller.
package enc_pkg;

    localparam int DATA_W = 8;
    localparam int NIB_W  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Expansion of the right nibble into a full byte before key mixing.
    function automatic logic [DATA_W-1:0] exp_box(input logic [NIB_W-1:0] n);
        return {n[3], n[0], n[1], n[2], n[1], n[3], n[2], n[0]};
    endfunction

    function automatic logic [DATA_W-1:0] rotl8(input logic [DATA_W-1:0] v, input logic [2:0] sh);
        logic [2*DATA_W-1:0] d;
        d = {v, v} << sh;
        return d[2*DATA_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rotr8(input logic [DATA_W-1:0] v, input logic [2:0] sh);
        logic [2*DATA_W-1:0] d;
        d = {v, v} >> sh;
        return d[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/enc_round.sv
// One combinational Feistel round: the left nibble is masked by a 4-bit
// function of the expanded right nibble and the round key.
module enc_round
    import enc_pkg::*;
(
    input  logic [DATA_W-1:0] n,
    input  logic [DATA_W-1:0] k,
    output logic [DATA_W-1:0] r
);

    logic [DATA_W-1:0] x;
    logic [NIB_W-1:0]  s;

    // 4-bit sum, carry-out intentionally dropped
    assign x = exp_box(n[NIB_W-1:0]) ^ k;
    assign s = x[NIB_W-1:0] + x[DATA_W-1:NIB_W] + {{(NIB_W-1){1'b0}}, k[0]};
    assign r = {n[DATA_W-1:NIB_W] ^ s, n[NIB_W-1:0]};

endmodule

// File: rtl/enc_round_ctrl.sv
// Multi-round sequencer around enc_round: accept, iterate ROUNDS times, hold result.
// Optional ENC_DECRYPT_EN adds in_decrypt and a reversed key schedule.
module enc_round_ctrl
    import enc_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_number,
    input  logic [DATA_W-1:0] in_key,
`ifdef ENC_DECRYPT_EN
    input  logic              in_decrypt,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_number,
    output logic              busy,
    output logic [CNT_W-1:0]  round_cnt
);

    state_t            state;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] key_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] round_r;
    logic [DATA_W-1:0] data_nxt;
    logic [DATA_W-1:0] key_nxt;
    logic [DATA_W-1:0] key_load;
    logic              last_round;
    logic              dec_in;
    logic              mode_q;

`ifdef ENC_DECRYPT_EN
    assign dec_in = in_decrypt;

    always_ff @(posedge clock) begin
        if (reset)
            mode_q <= 1'b0;
        else if (state == IDLE && in_valid)
            mode_q <= in_decrypt;
    end
`else
    assign dec_in = 1'b0;
    assign mode_q = 1'b0;
`endif

    enc_round u_round (
        .n (data_q),
        .k (key_q),
        .r (round_r)
    );

    assign last_round = (cnt_q == CNT_W'(ROUNDS - 1));
    // Halves are swapped between rounds but not after the final one.
    assign data_nxt   = last_round ? round_r : {round_r[NIB_W-1:0], round_r[DATA_W-1:NIB_W]};
    assign key_nxt    = mode_q ? rotr8(key_q, 3'd1) : rotl8(key_q, 3'd1);
    // Decryption walks the schedule backwards, starting at the last round key.
    assign key_load   = dec_in ? rotl8(in_key, 3'(ROUNDS - 1)) : in_key;

    assign out_number = data_q;
    assign round_cnt  = cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            data_q    <= '0;
            key_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_number;
                        key_q    <= key_load;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ROUND;
                    end
                end
                ROUND: begin
                    data_q <= data_nxt;
                    key_q  <= key_nxt;
                    if (last_round) begin
                        cnt_q     <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cnt_q     <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
